phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Per-phase duration timer for the washing-machine controller.
- Watches the controller FSM's `state` output and times how long the current phase has run.
- Returns a one-cycle `state_done` pulse to the FSM when the phase duration expires, closing the FSM↔timer loop.
- Also provides a one-second tick and an elapsed-seconds count for the display/debug path, and supports pausing during the spin phase.

Parameters:
- TICKS_PER_SEC, 1000000, clk cycles per second; must be ≥2.
- FILL_SEC, 60, filling-water duration in seconds; range 1..511.
- WASH_SEC, 300, washing duration in seconds; range 1..511.
- RINSE_SEC, 120, rinsing duration in seconds; range 1..511.
- SPIN_SEC, 60, spinning duration in seconds; range 1..511.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- state  input  3  current FSM phase: 000 IDLE, 001 FILLING_WATER, 010 WASHING, 011 RINSING, 100 SPINNING
- timer_pause  input  1  pause request; honoured only while state=100
- state_done  output  1  registered one-cycle pulse when the current phase duration expires
- sec_tick  output  1  registered one-cycle pulse each time elapsed_sec increments
- elapsed_sec  output  9  whole seconds elapsed in the current phase

Behaviour:
- Reset: only clk and rst, sampled on the rising edge of clk. When rst=1 at an edge:
  - presc ← 0, elapsed_sec ← 0, state_q ← 000, done_flag ← 0;
  - state_done ← 0, sec_tick ← 0.
  - This applies at any point, including mid-phase.
- Internal state:
  - presc: prescaler, width clog2(TICKS_PER_SEC).
  - state_q: registered copy of `state`.
  - done_flag: phase has already expired.
- Duration mux: DUR = FILL_SEC / WASH_SEC / RINSE_SEC / SPIN_SEC for 001 / 010 / 011 / 100.
- Timed states: 001–100. IDLE and the illegal codes 101–111 are untimed.
- Phase change (priority 1, below rst): when state ≠ state_q at an edge:
  - presc ← 0, elapsed_sec ← 0, done_flag ← 0, state_q ← state;
  - state_done ← 0, sec_tick ← 0.
  - The change cycle itself is not counted.
- Enable: en = timed state AND done_flag=0 AND NOT (state=100 AND timer_pause=1).
- Counting (priority 2): when en=1:
  - If presc = TICKS_PER_SEC−1: presc ← 0, elapsed_sec ← elapsed_sec+1, sec_tick ← 1.
    - If elapsed_sec+1 = DUR, also state_done ← 1 and done_flag ← 1.
  - Otherwise: presc ← presc+1.
- Default: sec_tick and state_done return to 0 every cycle they are not set.
- When en=0: presc and elapsed_sec hold.
- Latency: if `state` changes during cycle N, state_done is high during exactly cycle N + DUR·TICKS_PER_SEC + 1, counting unpaused cycles only.
- After expiry:
  - No further pulses while state stays unchanged.
  - elapsed_sec holds at DUR until the next phase change. The FSM advances on the pulse.
- Untimed states (000, 101–111):
  - presc and elapsed_sec are held at 0;
  - state_done and sec_tick stay 0.
- Pause:
  - A pause in a non-spin state is ignored.
  - A pause in the same cycle as the terminal tick suppresses that tick; it occurs on the first unpaused cycle instead.
- Simultaneous events:
  - A state change in the cycle the terminal tick would occur wins: counters are cleared and no pulse is issued.
  - Re-entering the same phase value with no intervening different value is not a change. The FSM always passes through another state first.
- elapsed_sec never exceeds DUR and never wraps.

Test Plan:
Bench parameters: TICKS_PER_SEC=4, FILL_SEC=2, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=2.
- Reset released, state 000→001 in cycle 0 → sec_tick in cycles 5 and 9; state_done high in cycle 9 only; elapsed_sec=2 from cycle 9.
- Hold state=001 for a further 20 cycles after the pulse → state_done and sec_tick stay 0; elapsed_sec stays 2.
- state→100 in cycle 0, timer_pause=1 in cycles 3–7 → state_done only in cycle 14; elapsed_sec frozen at 0 during the pause.
- state→010 in cycle 0, timer_pause=1 in cycles 2–6 → pause ignored; state_done only in cycle 13.
- state=001 for 5 cycles, then →010 in cycle 5 → elapsed_sec=0 in cycle 6; no FILL pulse; state_done only in cycle 18.
- rst=1 in cycle 3 of a 011 phase → all outputs 0 in cycle 4; state=000 or 101 for 30 cycles → no pulses, elapsed_sec=0.

Source files
------------

// File: rtl/phase_timer.sv
// Per-phase duration timer for the washing-machine controller: times the phase
// selected by the FSM, pulses state_done on expiry, and reports elapsed seconds.
module phase_timer #(
    parameter int unsigned TICKS_PER_SEC = 1000000,
    parameter int unsigned FILL_SEC      = 60,
    parameter int unsigned WASH_SEC      = 300,
    parameter int unsigned RINSE_SEC     = 120,
    parameter int unsigned SPIN_SEC      = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    input  logic       timer_pause,
    output logic       state_done,
    output logic       sec_tick,
    output logic [8:0] elapsed_sec
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_FILL  = 3'b001;
    localparam logic [2:0] ST_WASH  = 3'b010;
    localparam logic [2:0] ST_RINSE = 3'b011;
    localparam logic [2:0] ST_SPIN  = 3'b100;

    logic [PW-1:0] presc;
    logic [2:0]    state_q;
    logic          done_flag;
    logic          timed;
    logic          en;
    logic [8:0]    dur;
    logic [8:0]    elapsed_inc;

    always_comb begin
        dur   = '0;
        timed = 1'b0;
        case (state)
            ST_FILL:  begin dur = 9'(FILL_SEC);  timed = 1'b1; end
            ST_WASH:  begin dur = 9'(WASH_SEC);  timed = 1'b1; end
            ST_RINSE: begin dur = 9'(RINSE_SEC); timed = 1'b1; end
            ST_SPIN:  begin dur = 9'(SPIN_SEC);  timed = 1'b1; end
            default:  begin dur = '0;            timed = 1'b0; end
        endcase
    end

    // Pause only freezes the spin phase; other phases ignore it.
    assign en          = timed && !done_flag && !((state == ST_SPIN) && timer_pause);
    assign elapsed_inc = elapsed_sec + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            elapsed_sec <= '0;
            state_q     <= ST_IDLE;
            done_flag   <= 1'b0;
            state_done  <= 1'b0;
            sec_tick    <= 1'b0;
        end else begin
            state_done <= 1'b0;
            sec_tick   <= 1'b0;
            if (state != state_q) begin
                // A phase change wins over a coinciding terminal tick.
                presc       <= '0;
                elapsed_sec <= '0;
                done_flag   <= 1'b0;
                state_q     <= state;
            end else if (!timed) begin
                presc       <= '0;
                elapsed_sec <= '0;
            end else if (en) begin
                if (presc == PRESC_MAX) begin
                    presc       <= '0;
                    elapsed_sec <= elapsed_inc;
                    sec_tick    <= 1'b1;
                    if (elapsed_inc == dur) begin
                        state_done <= 1'b1;
                        done_flag  <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed phase scenarios plus random phase/pause/reset
// traffic, checked against a counted-cycles reference model.
module tb_phase_timer;

    localparam int unsigned T      = 4;
    localparam int unsigned F_SEC  = 2;
    localparam int unsigned W_SEC  = 3;
    localparam int unsigned R_SEC  = 2;
    localparam int unsigned S_SEC  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state = 3'b000;
    logic       timer_pause = 1'b0;
    logic       state_done;
    logic       sec_tick;
    logic [8:0] elapsed_sec;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycles counted in the current phase.
    int unsigned m_cnt   = 0;
    logic [2:0]  m_prev  = 3'b000;
    logic        m_done  = 1'b0;
    logic        m_tick  = 1'b0;

    int unsigned cyc      = 0;
    int unsigned base     = 0;
    int unsigned done_cyc = 0;
    int unsigned n_done   = 0;
    int unsigned n_tick   = 0;

    phase_timer #(
        .TICKS_PER_SEC(T),
        .FILL_SEC(F_SEC),
        .WASH_SEC(W_SEC),
        .RINSE_SEC(R_SEC),
        .SPIN_SEC(S_SEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .state(state),
        .timer_pause(timer_pause),
        .state_done(state_done),
        .sec_tick(sec_tick),
        .elapsed_sec(elapsed_sec)
    );

    always #5 clk = ~clk;

    function automatic int unsigned dur_of(input logic [2:0] s);
        case (s)
            3'b001:  return F_SEC;
            3'b010:  return W_SEC;
            3'b011:  return R_SEC;
            3'b100:  return S_SEC;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] s, input logic p, input logic r);
        int unsigned limit;
        state       = s;
        timer_pause = p;
        rst         = r;
        @(posedge clk);
        cyc++;
        limit  = dur_of(s) * T;
        m_tick = 1'b0;
        m_done = 1'b0;
        if (r) begin
            m_cnt  = 0;
            m_prev = 3'b000;
        end else if (s != m_prev) begin
            m_prev = s;
            m_cnt  = 0;
        end else if (limit != 0 && m_cnt < limit && !(s == 3'b100 && p)) begin
            m_cnt++;
            m_tick = (m_cnt % T) == 0;
            m_done = (m_cnt == limit);
        end
        #1;
        check("state_done", int'(state_done), int'(m_done));
        check("sec_tick", int'(sec_tick), int'(m_tick));
        check("elapsed_sec", int'(elapsed_sec), int'(m_cnt / T));
        if (state_done === 1'b1) begin
            done_cyc = cyc;
            n_done++;
        end
        if (sec_tick === 1'b1) n_tick++;
    endtask

    task automatic start_scenario();
        base   = cyc;
        n_done = 0;
        n_tick = 0;
    endtask

    initial begin
        logic [2:0]  rs;
        int unsigned hold;

        // Reset state
        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);

        // FILL from idle: ticks at 5 and 9, done at 9
        start_scenario();
        for (int i = 0; i < 10; i++) step(3'b001, 1'b0, 1'b0);
        check("fill_done_cycle", int'(done_cyc - base), 9);
        check("fill_tick_count", int'(n_tick), 2);
        check("fill_elapsed", int'(elapsed_sec), 2);
        for (int i = 0; i < 20; i++) step(3'b001, 1'b0, 1'b0);
        check("fill_done_once", int'(n_done), 1);
        check("fill_elapsed_hold", int'(elapsed_sec), 2);

        // SPIN with pause in cycles 3..7: done at 14
        step(3'b000, 1'b0, 1'b0);
        start_scenario();
        for (int i = 0; i < 16; i++) step(3'b100, (i >= 3 && i <= 7), 1'b0);
        check("spin_done_cycle", int'(done_cyc - base), 14);
        check("spin_done_once", int'(n_done), 1);

        // WASH with pause in cycles 2..6 ignored: done at 13
        step(3'b000, 1'b0, 1'b0);
        start_scenario();
        for (int i = 0; i < 16; i++) step(3'b010, (i >= 2 && i <= 6), 1'b0);
        check("wash_done_cycle", int'(done_cyc - base), 13);
        check("wash_done_once", int'(n_done), 1);

        // FILL interrupted by WASH in cycle 5: only the WASH pulse at 18
        step(3'b000, 1'b0, 1'b0);
        start_scenario();
        for (int i = 0; i < 5; i++) step(3'b001, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0);
        check("switch_elapsed_clear", int'(elapsed_sec), 0);
        for (int i = 0; i < 14; i++) step(3'b010, 1'b0, 1'b0);
        check("switch_done_cycle", int'(done_cyc - base), 18);
        check("switch_done_once", int'(n_done), 1);

        // Reset in cycle 3 of RINSE, then untimed states
        step(3'b000, 1'b0, 1'b0);
        start_scenario();
        for (int i = 0; i < 3; i++) step(3'b011, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b1);
        check("rst_mid_elapsed", int'(elapsed_sec), 0);
        check("rst_mid_done", int'(state_done), 0);
        for (int i = 0; i < 30; i++) step(($urandom_range(0, 1) != 0) ? 3'b101 : 3'b000, 1'b0, 1'b0);
        check("untimed_no_done", int'(n_done), 0);
        check("untimed_no_tick", int'(n_tick), 0);

        // Random phases, pauses and occasional reset
        for (int seg = 0; seg < 120; seg++) begin
            rs   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rs = 3'($urandom_range(1, 4));
            hold = $urandom_range(1, 45);
            for (int i = 0; i < int'(hold); i++)
                step(rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
